// File: rtl/tube_event_reader.sv
// ---------------------------------------------------------------------------
// tube_event_reader
//
// Read-side consumer of the 16-bit tube-hit FIFO. It pulls words from the
// FIFO and drops idle filler (low byte 0xFF) and held/repeated words. It
// decodes the tube address byte into a 0..31 tube index and presents each
// hit on a valid/ready stream, with event-boundary flags and an event number.
//
// Build option:
//   TUBE_SEQ_CHECK_EN  - when defined, a HUNT/COLLECT sequence checker only
//                        forwards hits that form an in-order 0..31 event. It
//                        pulses seq_err on a break. When undefined, every
//                        decoded hit is forwarded and seq_err is tied to 0.
//
// Parameters:
//   BUF_DEPTH   output skid-buffer entries, 2 or 4
//
// Ports:
//   clk100      system clock (also clocks the FIFO read side)
//   CLR_N       asynchronous active-low reset
//   fifo_dout   FIFO word: [15:8] drift time, [7:0] tube address code
//   fifo_empty  FIFO empty flag
//   fifo_valid  fifo_dout valid (one cycle after fifo_rd_en)
//   fifo_rd_en  FIFO read request
//   ev_valid    output hit available
//   ev_ready    downstream accepts the hit
//   ev_tube     tube index {chamber4, layerB, tube[2:0]}
//   ev_time     drift time
//   ev_first    hit is tube 0 (3A0)
//   ev_last     hit is tube 31 (4B7)
//   ev_num      event number of the presented hit
//   bad_cnt     saturating count of undecodable words
//   seq_err     one-cycle pulse on a sequence break
// ---------------------------------------------------------------------------
module tube_event_reader #(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk100,
    input  logic        CLR_N,
    input  logic [15:0] fifo_dout,
    input  logic        fifo_empty,
    input  logic        fifo_valid,
    output logic        fifo_rd_en,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [4:0]  ev_tube,
    output logic [7:0]  ev_time,
    output logic        ev_first,
    output logic        ev_last,
    output logic [15:0] ev_num,
    output logic [7:0]  bad_cnt,
    output logic        seq_err
);

    // Pointer and occupancy widths for a power-of-two buffer of 2 or 4.
    localparam int          PW      = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(BUF_DEPTH);

    typedef struct packed {
        logic [4:0] tube;
        logic [7:0] drift;
        logic       first;
        logic       last;
    } hit_t;

    // -----------------------------------------------------------------------
    // Word filter and address decode
    // -----------------------------------------------------------------------
    logic [7:0] code;
    logic [7:0] prev_code_q;
    logic       is_idle;
    logic       is_rep;
    logic       is_ch3;
    logic       is_ch4;
    logic [4:0] dec_idx;
    logic       word_new;
    logic       dec_ok;
    logic       dec_bad;
    logic       accept;

    assign code = fifo_dout[7:0];

    always_comb begin
        is_idle  = (code == 8'hFF);
        is_rep   = (code == prev_code_q);
        is_ch3   = (code[7:4] == 4'hC);
        is_ch4   = (code[7:4] == 4'h2);
        // Tube bits are stored bit-reversed in the code.
        dec_idx  = {is_ch4, code[3], code[0], code[1], code[2]};
        word_new = fifo_valid && !is_idle && !is_rep;
        dec_ok   = word_new && (is_ch3 || is_ch4);
        dec_bad  = word_new && !(is_ch3 || is_ch4);
    end

    // Idle words load 0xFF, and a repeat loads the value already held, so
    // every valid word can simply be captured.
    always_ff @(posedge clk100 or negedge CLR_N) begin
        if (!CLR_N) begin
            prev_code_q <= 8'hFF;
        end else if (fifo_valid) begin
            // NOTE: sequential state is always written with <=, so every
            // flop samples pre-edge values regardless of block order.
            prev_code_q <= code;
        end
    end

    always_ff @(posedge clk100 or negedge CLR_N) begin
        if (!CLR_N) begin
            bad_cnt <= 8'd0;
        end else if (dec_bad && (bad_cnt != 8'hFF)) begin
            bad_cnt <= bad_cnt + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Optional HUNT/COLLECT sequence checker
    // -----------------------------------------------------------------------
`ifdef TUBE_SEQ_CHECK_EN
    typedef enum logic {
        HUNT,
        COLLECT
    } seq_state_t;

    seq_state_t state_q;
    seq_state_t state_d;
    logic [4:0] expect_q;
    logic [4:0] expect_d;
    logic       seq_err_d;
    logic       seq_err_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        expect_d  = expect_q;
        accept    = 1'b0;
        seq_err_d = 1'b0;
        if (dec_ok) begin
            unique case (state_q)
                HUNT: begin
                    if (dec_idx == 5'd0) begin
                        accept   = 1'b1;
                        state_d  = COLLECT;
                        expect_d = 5'd1;
                    end
                end
                COLLECT: begin
                    if (dec_idx == expect_q) begin
                        accept = 1'b1;
                        if (dec_idx == 5'd31) begin
                            state_d = HUNT;
                        end else begin
                            expect_d = expect_q + 5'd1;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        if (dec_idx == 5'd0) begin
                            // A fresh tube 0 restarts the event immediately.
                            accept   = 1'b1;
                            expect_d = 5'd1;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk100 or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q   <= HUNT;
            expect_q  <= 5'd0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            expect_q  <= expect_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign accept  = dec_ok;
    assign seq_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Output skid buffer and FIFO read control
    // -----------------------------------------------------------------------
    hit_t            buf_q [BUF_DEPTH];
    hit_t            head;
    hit_t            new_hit;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            inflight_q;
    logic            run_q;
    logic            pop;
    logic [CW:0]     occ;

    always_comb begin
        new_hit.tube  = dec_idx;
        new_hit.drift = fifo_dout[15:8];
        new_hit.first = (dec_idx == 5'd0);
        new_hit.last  = (dec_idx == 5'd31);
    end

    assign head     = buf_q[rd_ptr_q];
    assign ev_valid = (count_q != '0);
    assign pop      = ev_valid && ev_ready;

    // Occupancy counts this cycle's pop so a steadily drained buffer keeps
    // one read in flight every cycle. Reads already in flight are reserved,
    // so the buffer can never overflow.
    assign occ        = {1'b0, count_q} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight_q};
    assign fifo_rd_en = run_q && !fifo_empty && (occ < DEPTH_L);

    always_ff @(posedge clk100 or negedge CLR_N) begin
        if (!CLR_N) begin
            run_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk100 or negedge CLR_N) begin
        if (!CLR_N) begin
            // NOTE: the buffer is only a few entries and drives the outputs
            // directly, so it is reset to give all-zero outputs out of reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                buf_q[wr_ptr_q] <= new_hit;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(accept) - CW'(pop);
        end
    end

    always_ff @(posedge clk100 or negedge CLR_N) begin
        if (!CLR_N) begin
            ev_num <= 16'd0;
        end else if (pop && head.last) begin
            ev_num <= ev_num + 16'd1;
        end
    end

    assign ev_tube  = head.tube;
    assign ev_time  = head.drift;
    assign ev_first = head.first;
    assign ev_last  = head.last;

endmodule

// File: tb/tb_tube_event_reader.sv
// ---------------------------------------------------------------------------
// tb_tube_event_reader
//
// Directed bench for tube_event_reader with the default BUF_DEPTH. A small
// FIFO model with one-cycle read latency feeds the design. A negedge monitor
// drives ev_ready and records every accepted hit, and the main sequence
// compares those hits against expected events built from the tube encoding.
// ---------------------------------------------------------------------------
module tb_tube_event_reader;

    logic        clk100     = 1'b0;
    logic        CLR_N      = 1'b0;
    logic [15:0] fifo_dout  = 16'h0000;
    logic        fifo_empty = 1'b1;
    logic        fifo_valid = 1'b0;
    logic        fifo_rd_en;
    logic        ev_valid;
    logic        ev_ready   = 1'b1;
    logic [4:0]  ev_tube;
    logic [7:0]  ev_time;
    logic        ev_first;
    logic        ev_last;
    logic [15:0] ev_num;
    logic [7:0]  bad_cnt;
    logic        seq_err;

    always #5 clk100 = ~clk100;

    tube_event_reader dut (
        .clk100     (clk100),
        .CLR_N      (CLR_N),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_valid (fifo_valid),
        .fifo_rd_en (fifo_rd_en),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_tube    (ev_tube),
        .ev_time    (ev_time),
        .ev_first   (ev_first),
        .ev_last    (ev_last),
        .ev_num     (ev_num),
        .bad_cnt    (bad_cnt),
        .seq_err    (seq_err)
    );

    typedef struct packed {
        logic [4:0]  tube;
        logic [7:0]  drift;
        logic        first;
        logic        last;
        logic [15:0] num;
    } hit_t;

    int          checks     = 0;
    int          failures   = 0;
    logic [15:0] q[$];
    hit_t        got[$];
    int          got_cyc[$];
    int          cyc        = 0;
    int          stall_viol = 0;
    int          rd_hold    = 0;
    int          seq_pulses = 0;
    bit          bp_mode    = 1'b0;
    bit          stall_prev = 1'b0;
    hit_t        stall_val;
    hit_t        cur;

    // FIFO model: a read request returns the head word one cycle later.
    always @(posedge clk100) begin
        if (fifo_rd_en && (q.size() > 0)) begin
            fifo_dout  <= q.pop_front();
            fifo_valid <= 1'b1;
        end else begin
            fifo_valid <= 1'b0;
        end
        fifo_empty <= (q.size() == 0);
    end

    // Monitor: sets ev_ready for the coming edge, then records what that
    // edge will transfer and whether a stalled hit held still.
    always @(negedge clk100) begin
        cyc++;
        ev_ready = bp_mode ? ~ev_ready : 1'b1;
        cur = {ev_tube, ev_time, ev_first, ev_last, ev_num};
        if (stall_prev && (!ev_valid || (cur != stall_val))) stall_viol++;
        stall_prev = ev_valid && !ev_ready;
        stall_val  = cur;
        if (ev_valid && ev_ready) begin
            got.push_back(cur);
            got_cyc.push_back(cyc);
        end
        if (seq_err) seq_pulses++;
        #1;
        if (CLR_N && !fifo_empty && !fifo_rd_en) rd_hold++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] drift_of(input int i);
        return 8'(5 + 2 * i);
    endfunction

    // Writer-side encoding: chamber 3 -> 0xC0, chamber 4 -> 0x20,
    // low nibble {layerB, bit-reversed tube}.
    function automatic logic [15:0] word_of(input int i);
        logic [4:0] ix;
        logic [7:0] c;
        ix = 5'(i);
        c  = (ix[4] ? 8'h20 : 8'hC0) | {4'b0000, ix[3], ix[0], ix[1], ix[2]};
        return {drift_of(i), c};
    endfunction

    function automatic hit_t exp_hit(input int i, input logic [15:0] num);
        hit_t h;
        h.tube  = 5'(i);
        h.drift = drift_of(i);
        h.first = (i == 0);
        h.last  = (i == 31);
        h.num   = num;
        return h;
    endfunction

    // Idle, 32 writer words (optionally one omitted, optionally held for
    // extra cycles, optionally followed by a bad code), last word held 11
    // more times, idle.
    task automatic push_event(input int skip, input int bad_after, input bit reps);
        q.push_back(16'h00FF);
        for (int i = 0; i < 32; i++) begin
            if (i != skip) begin
                for (int r = 0; r < 1 + (reps ? (i % 3) : 0); r++) q.push_back(word_of(i));
            end
            if (i == bad_after) q.push_back(16'h1234);
        end
        for (int r = 0; r < 11; r++) q.push_back(word_of(31));
        q.push_back(16'h00FF);
    endtask

    task automatic clear_mon();
        @(posedge clk100);
        #1;
        got.delete();
        got_cyc.delete();
        seq_pulses = 0;
        rd_hold    = 0;
        stall_viol = 0;
    endtask

    // Waits for n hits within a cycle budget, then idles so extra hits
    // would also show up in the count.
    task automatic wait_hits(input int n, input int budget);
        int k;
        k = 0;
        while ((got.size() < n) && (k < budget)) begin
            @(negedge clk100);
            k++;
        end
        repeat (20) @(negedge clk100);
    endtask

    task automatic check_event(input string tag, input int base, input logic [15:0] num,
                               input int skip, input int last_i);
        int j;
        j = base;
        for (int i = 0; i <= last_i; i++) begin
            if (i != skip) begin
                if (j < got.size()) check($sformatf("%s_hit%0d", tag, i), got[j], exp_hit(i, num));
                j++;
            end
        end
    endtask

    initial begin
        int k;

        // ---------------- reset state ----------------
        q.push_back(16'h00FF);
        repeat (2) @(negedge clk100);
        check("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_ev_valid",   32'(ev_valid),   32'd0);
        check("rst_ev_tube",    32'(ev_tube),    32'd0);
        check("rst_ev_time",    32'(ev_time),    32'd0);
        check("rst_ev_first",   32'(ev_first),   32'd0);
        check("rst_ev_last",    32'(ev_last),    32'd0);
        check("rst_ev_num",     32'(ev_num),     32'd0);
        check("rst_bad_cnt",    32'(bad_cnt),    32'd0);
        check("rst_seq_err",    32'(seq_err),    32'd0);
        CLR_N = 1'b1;

        // ---------------- full event, latency, throughput ----------------
        clear_mon();
        push_event(-1, -1, 1'b0);
        k = 0;
        while (!(fifo_valid && (fifo_dout == 16'h05C0)) && (k < 50)) begin
            @(negedge clk100);
            k++;
        end
        check("lat_word_seen", 32'(k < 50), 32'd1);
        @(negedge clk100);
        check("lat_ev_valid", 32'(ev_valid), 32'd1);
        check("lat_ev_tube",  32'(ev_tube),  32'd0);
        check("lat_ev_time",  32'(ev_time),  32'h05);
        check("lat_ev_first", 32'(ev_first), 32'd1);
        wait_hits(32, 300);
        check("full_count", 32'(got.size()), 32'd32);
        check_event("full", 0, 16'd0, -1, 31);
        if (got_cyc.size() >= 32) check("full_throughput", 32'(got_cyc[31] - got_cyc[0]), 32'd31);
        check("full_ev_num", 32'(ev_num), 32'd1);

        // ---------------- backpressure ----------------
        clear_mon();
        bp_mode = 1'b1;
        push_event(-1, -1, 1'b1);
        wait_hits(32, 600);
        bp_mode = 1'b0;
        check("bp_count", 32'(got.size()), 32'd32);
        check_event("bp", 0, 16'd1, -1, 31);
        check("bp_stall_stable", 32'(stall_viol), 32'd0);
        check("bp_rd_en_drops", 32'(rd_hold != 0), 32'd1);
        check("bp_ev_num", 32'(ev_num), 32'd2);

        // ---------------- bad code mid-event ----------------
        clear_mon();
        push_event(-1, 10, 1'b0);
        wait_hits(32, 300);
        check("bad_count", 32'(got.size()), 32'd32);
        check_event("bad", 0, 16'd2, -1, 31);
        check("bad_cnt", 32'(bad_cnt), 32'd1);
        check("bad_ev_num", 32'(ev_num), 32'd3);

        // ---------------- sequence break (tube 5 omitted) ----------------
        clear_mon();
        push_event(5, -1, 1'b0);
        push_event(-1, -1, 1'b0);
`ifdef TUBE_SEQ_CHECK_EN
        wait_hits(37, 500);
        check("seq_count", 32'(got.size()), 32'd37);
        check_event("seq_broken", 0, 16'd3, -1, 4);
        check_event("seq_next", 5, 16'd3, -1, 31);
        check("seq_err_pulses", 32'(seq_pulses), 32'd1);
        check("seq_ev_num", 32'(ev_num), 32'd4);
`else
        wait_hits(63, 500);
        check("seq_count", 32'(got.size()), 32'd63);
        check_event("seq_broken", 0, 16'd3, 5, 31);
        check_event("seq_next", 31, 16'd4, -1, 31);
        check("seq_err_pulses", 32'(seq_pulses), 32'd0);
        check("seq_ev_num", 32'(ev_num), 32'd5);
`endif

        // ---------------- reset mid-event ----------------
        clear_mon();
        push_event(-1, -1, 1'b0);
        k = 0;
        while ((got.size() < 11) && (k < 200)) begin
            @(negedge clk100);
            k++;
        end
        check("mid_reached_hit10", 32'(got.size() >= 11), 32'd1);
        @(posedge clk100);
        #1;
        CLR_N = 1'b0;
        q.delete();
        got.delete();
        got_cyc.delete();
        push_event(-1, -1, 1'b0);
        @(negedge clk100);
        check("mid_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check("mid_ev_valid",   32'(ev_valid),   32'd0);
        check("mid_ev_tube",    32'(ev_tube),    32'd0);
        check("mid_ev_time",    32'(ev_time),    32'd0);
        check("mid_ev_first",   32'(ev_first),   32'd0);
        check("mid_ev_last",    32'(ev_last),    32'd0);
        check("mid_ev_num",     32'(ev_num),     32'd0);
        check("mid_bad_cnt",    32'(bad_cnt),    32'd0);
        check("mid_seq_err",    32'(seq_err),    32'd0);
        repeat (2) @(negedge clk100);
        CLR_N = 1'b1;
        wait_hits(32, 300);
        check("mid_count", 32'(got.size()), 32'd32);
        check_event("mid", 0, 16'd0, -1, 31);
        check("mid_ev_num_after", 32'(ev_num), 32'd1);

        // ---------------- ev_num wrap ----------------
        force dut.ev_num = 16'hFFFF;
        @(posedge clk100);
        #1;
        release dut.ev_num;
        @(negedge clk100);
        check("wrap_preload", 32'(ev_num), 32'h0000FFFF);
        clear_mon();
        push_event(-1, -1, 1'b0);
        wait_hits(32, 300);
        check("wrap_count", 32'(got.size()), 32'd32);
        check_event("wrap", 0, 16'hFFFF, -1, 31);
        check("wrap_ev_num", 32'(ev_num), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
